ctrl_hazard_pipe: RTL and testbench

Pipelined consumer of the per-instruction control word produced by the D-stage decoder. It carries each instruction's destination register, write enable and result-ready countdown through the E, M and W stages. It uses those records to generate the D-stage stall and the D- and E-stage forwarding selects. It sits beside the D/E, E/M and M/W datapath registers in the five-stage core and owns every hazard decision.

---
 rtl/ctrl_hazard_pipe.sv | 133 +++++++++++++
 tb/tb_ctrl_hazard_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_hazard_pipe.sv
// Purpose : hazard unit for the five-stage core. It tracks {we, A3, Tnew} of the E/M/W instructions and drives stall and forwarding selects.
// Latency : stall and all forwarding selects are combinational from the D inputs and the stage records (0 cycles); records advance every clock.
// Backpressure: stall=1 freezes PC and F/D upstream and puts a bubble into E. No other flow control is involved.
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset clears every stage record
//   D_rs, D_rt, D_Tuse_rs/rt    D-stage source indices and their use deadlines (3 = operand unused)
//   D_GRFWrite, D_A3, D_Tnew    D-stage destination record
//   stall                       freeze request for F/D
//   D_fwd_rs/rt, E_fwd_rs/rt    forwarding selects: 0 = own register, 1 = M result, 2 = W result
//   stall_cnt                   count of stall cycles (HAZARD_STALL_COUNT_EN); tied to 0 otherwise
//
// Build option: define HAZARD_STALL_COUNT_EN to build the stall counter.

module ctrl_hazard_pipe #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] D_rs,
  input  logic [REG_W-1:0] D_rt,
  input  logic [1:0]       D_Tuse_rs,
  input  logic [1:0]       D_Tuse_rt,
  input  logic             D_GRFWrite,
  input  logic [REG_W-1:0] D_A3,
  input  logic [1:0]       D_Tnew,
  output logic             stall,
  output logic [1:0]       D_fwd_rs,
  output logic [1:0]       D_fwd_rt,
  output logic [1:0]       E_fwd_rs,
  output logic [1:0]       E_fwd_rt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic             we;
    logic [REG_W-1:0] a3;
    logic [1:0]       tnew;
  } rec_t;

  rec_t             e_rec, m_rec, w_rec;
  logic [REG_W-1:0] e_rs, e_rt;
  rec_t             d_rec;

  // Writes to $0 are folded into we=0 here, so no later comparison has to
  // special-case register 0 on the destination side.
  always_comb begin
    d_rec      = '0;
    d_rec.we   = D_GRFWrite && (D_A3 != '0);
    d_rec.a3   = D_A3;
    d_rec.tnew = D_Tnew;
  end

  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Operand needs a value that no stage can supply in time.
  function automatic logic op_stall(input logic [REG_W-1:0] idx,
                                    input logic [1:0]       tuse,
                                    input rec_t             e,
                                    input rec_t             m);
    logic hit;
    hit = 1'b0;
    if (tuse != 2'd3 && idx != '0) begin
      if (e.we && e.a3 == idx && e.tnew > tuse) hit = 1'b1;
      if (m.we && m.a3 == idx && m.tnew > tuse) hit = 1'b1;
    end
    return hit;
  endfunction

  // M is checked first: it carries the younger of two writes to the same register.
  // M only qualifies once its result actually exists (Tnew == 0).
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] idx,
                                         input rec_t             m,
                                         input rec_t             w);
    logic [1:0] sel;
    sel = 2'd0;
    if (m.we && m.a3 == idx && m.tnew == 2'd0) sel = 2'd1;
    else if (w.we && w.a3 == idx)              sel = 2'd2;
    return sel;
  endfunction

  always_comb begin
    stall    = op_stall(D_rs, D_Tuse_rs, e_rec, m_rec) ||
               op_stall(D_rt, D_Tuse_rt, e_rec, m_rec);
    // The E record is deliberately not a D-stage source: an E match either
    // stalls or reaches M with Tnew == 0 one cycle later.
    D_fwd_rs = fwd_sel(D_rs, m_rec, w_rec);
    D_fwd_rt = fwd_sel(D_rt, m_rec, w_rec);
    E_fwd_rs = fwd_sel(e_rs, m_rec, w_rec);
    E_fwd_rt = fwd_sel(e_rt, m_rec, w_rec);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_rec <= '0;
      m_rec <= '0;
      w_rec <= '0;
      e_rs  <= '0;
      e_rt  <= '0;
    end else begin
      w_rec      <= m_rec;
      w_rec.tnew <= dec_sat(m_rec.tnew);
      m_rec      <= e_rec;
      m_rec.tnew <= dec_sat(e_rec.tnew);
      if (stall) begin
        e_rec <= '0;
        e_rs  <= '0;
        e_rt  <= '0;
      end else begin
        e_rec <= d_rec;
        e_rs  <= D_rs;
        e_rt  <= D_rt;
      end
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset)      cnt_q <= '0;
    else if (stall) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_hazard_pipe.sv
// Purpose : scoreboard bench for ctrl_hazard_pipe against an instruction-history reference model.
// Latency : expectations are pushed when inputs are driven and popped by the monitor on the falling edge of the same cycle.
// Backpressure: the driver re-issues a D instruction while the model predicts a stall, as the real F/D register would.

module tb_ctrl_hazard_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs, D_rt, D_A3;
  logic [1:0]  D_Tuse_rs, D_Tuse_rt, D_Tnew;
  logic        D_GRFWrite;
  logic        stall;
  logic [1:0]  D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt;
  logic [31:0] stall_cnt;

  ctrl_hazard_pipe #(.REG_W(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .D_GRFWrite(D_GRFWrite), .D_A3(D_A3), .D_Tnew(D_Tnew),
    .stall(stall), .D_fwd_rs(D_fwd_rs), .D_fwd_rt(D_fwd_rt),
    .E_fwd_rs(E_fwd_rs), .E_fwd_rt(E_fwd_rt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        st;
    logic [1:0]  dfs, dft, efs, eft;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the last three instructions that entered E, index = age
  // (0 = in E, 1 = in M, 2 = in W). A result is ready at age k after
  // max(Tnew - k, 0) more cycles.
  bit          h_we[3];
  int          h_a3[3];
  int          h_tn[3];
  int          h_rs, h_rt;
  logic [31:0] m_cnt;
  bit          last_stall;

  function automatic int ready_in(int k);
    return (h_tn[k] - k > 0) ? h_tn[k] - k : 0;
  endfunction

  function automatic bit needs_wait(int idx, int tuse);
    if (tuse == 3 || idx == 0) return 1'b0;
    for (int k = 0; k < 2; k++)
      if (h_we[k] && h_a3[k] == idx && ready_in(k) > tuse) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] source_of(int idx);
    if (h_we[1] && h_a3[1] == idx && ready_in(1) == 0) return 2'd1;
    if (h_we[2] && h_a3[2] == idx) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      h_we[k] = 1'b0; h_a3[k] = 0; h_tn[k] = 0;
    end
    h_rs = 0; h_rt = 0; m_cnt = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One clock: drive D, predict outputs, hand the prediction to the monitor,
  // then advance the model across the rising edge.
  task automatic step(input bit rst, input int rs, input int rt, input int tur,
                      input int tut, input bit gw, input int a3, input int tn);
    exp_t e;
    reset = rst; D_rs = 5'(rs); D_rt = 5'(rt);
    D_Tuse_rs = 2'(tur); D_Tuse_rt = 2'(tut);
    D_GRFWrite = gw; D_A3 = 5'(a3); D_Tnew = 2'(tn);
    e.st  = needs_wait(rs, tur) || needs_wait(rt, tut);
    e.dfs = source_of(rs);
    e.dft = source_of(rt);
    e.efs = source_of(h_rs);
    e.eft = source_of(h_rt);
`ifdef HAZARD_STALL_COUNT_EN
    e.cnt = m_cnt;
`else
    e.cnt = '0;
`endif
    exp_q.push_back(e);
    last_stall = e.st;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (e.st) m_cnt = m_cnt + 32'd1;
      for (int k = 2; k > 0; k--) begin
        h_we[k] = h_we[k-1]; h_a3[k] = h_a3[k-1]; h_tn[k] = h_tn[k-1];
      end
      h_we[0] = e.st ? 1'b0 : (gw && a3 != 0);
      h_a3[0] = e.st ? 0 : a3;
      h_tn[0] = e.st ? 0 : tn;
      h_rs    = e.st ? 0 : rs;
      h_rt    = e.st ? 0 : rt;
    end
    #1;
  endtask

  // Issue one instruction, holding it in D for as long as it is stalled.
  task automatic instr(input int rs, input int rt, input int tur, input int tut,
                       input bit gw, input int a3, input int tn);
    int guard = 0;
    do begin
      step(1'b0, rs, rt, tur, tut, gw, a3, tn);
      guard++;
    end while (last_stall && guard < 4);
  endtask

  task automatic nop();
    step(1'b0, 0, 0, 3, 3, 1'b0, 0, 0);
  endtask

  // Monitor: the DUT presents a result every cycle; compare on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("stall",     {31'd0, stall}, {31'd0, e.st});
        chk("D_fwd_rs",  {30'd0, D_fwd_rs}, {30'd0, e.dfs});
        chk("D_fwd_rt",  {30'd0, D_fwd_rt}, {30'd0, e.dft});
        chk("E_fwd_rs",  {30'd0, E_fwd_rs}, {30'd0, e.efs});
        chk("E_fwd_rt",  {30'd0, E_fwd_rt}, {30'd0, e.eft});
        chk("stall_cnt", stall_cnt, e.cnt);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; D_rs = '0; D_rt = '0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3;
    D_GRFWrite = 1'b0; D_A3 = '0; D_Tnew = '0;
    model_clear();
    last_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset while a load to $8 sits in E and D wants $8 in D: nothing survives.
    instr(0, 0, 3, 3, 1'b1, 8, 2);
    step(1'b1, 8, 0, 0, 3, 1'b0, 0, 0);
    step(1'b0, 8, 0, 0, 3, 1'b0, 0, 0);
    repeat (2) nop();

    // Load-use: lw $8 then addu $8 -> one stall, then W forwarding in E.
    instr(0, 0, 3, 3, 1'b1, 8, 2);
    instr(8, 0, 1, 3, 1'b1, 11, 1);
    repeat (3) nop();

    // addu $9 then beq $9 -> one stall, then M forwarding into D.
    instr(0, 0, 3, 3, 1'b1, 9, 1);
    instr(9, 0, 0, 0, 1'b0, 0, 0);
    repeat (3) nop();

    // lw $10 then beq $10 -> two stalls, then W forwarding into D.
    instr(0, 0, 3, 3, 1'b1, 10, 2);
    instr(0, 10, 0, 0, 1'b0, 0, 0);
    repeat (3) nop();

    // Two writers of $5 back to back: the younger one (M) must win.
    instr(0, 0, 3, 3, 1'b1, 5, 1);
    instr(0, 0, 3, 3, 1'b1, 5, 1);
    instr(5, 5, 1, 1, 1'b1, 12, 1);
    repeat (3) nop();

    // Writes to $0 never stall or forward.
    instr(0, 0, 3, 3, 1'b1, 0, 2);
    instr(0, 0, 0, 0, 1'b0, 0, 0);
    instr(0, 0, 1, 1, 1'b1, 0, 1);
    instr(0, 0, 0, 0, 1'b0, 0, 0);
    repeat (3) nop();

    // Reset in the middle of a two-cycle branch stall clears the counter too.
    instr(0, 0, 3, 3, 1'b1, 10, 2);
    step(1'b0, 10, 0, 0, 3, 1'b0, 0, 0);
    step(1'b1, 10, 0, 0, 3, 1'b0, 0, 0);
    step(1'b0, 10, 0, 0, 3, 1'b0, 0, 0);
    repeat (2) nop();

    // Randomized traffic over a small register set to provoke many hazards.
    for (int i = 0; i < 2000; i++) begin
      int tsel_a, tsel_b;
      tsel_a = $urandom_range(0, 2);
      tsel_b = $urandom_range(0, 2);
      step(($urandom_range(0, 59) == 0),
           $urandom_range(0, 7), $urandom_range(0, 7),
           (tsel_a == 2) ? 3 : tsel_a, (tsel_b == 2) ? 3 : tsel_b,
           $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
